// File: rtl/axil_chip_pkg.sv
// Shared types and constants for the axil_chip AXI4-Lite memory slave.
package axil_chip_pkg;

  typedef logic [1:0] axil_resp_t;

  localparam axil_resp_t RESP_OKAY   = 2'b00;
  localparam axil_resp_t RESP_SLVERR = 2'b10;
  localparam axil_resp_t RESP_DECERR = 2'b11;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_MEM_DEPTH  = 1024;

endpackage

// File: rtl/axil_chip_ram.sv
// Word-wide storage with one byte-enabled synchronous write port and one
// synchronous read port. A read and write of the same word on the same edge
// returns the data held before that edge. Contents are never cleared.
module axil_chip_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                         i_clk,
  input  logic                         i_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0]        i_wdata,
  input  logic [DATA_WIDTH/8-1:0]      i_wstrb,
  input  logic                         i_re,
  input  logic [$clog2(MEM_DEPTH)-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0]        o_rdata
);

  localparam int STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Byte-lane write and registered read; the read output only moves on i_re
  // so the caller can hold it for as long as the response is stalled.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (i_wstrb[b]) begin
          r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axil_chip.sv
// AXI4-Lite slave in front of a byte-enabled word memory.
// Write and read channels are independent, one transaction in flight each.
// Optional macro AXIL_CHIP_DECERR_EN: out-of-range accesses answer DECERR
// (no write, read data 0). Without it the address wraps modulo the memory.
module axil_chip
  import axil_chip_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MEM_DEPTH  = DEF_MEM_DEPTH
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic [2:0]              s_awprot,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic [2:0]              s_arprot,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rvalid,
  input  logic                    s_rready
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_DEPTH);

  // Write channel state
  logic                  r_awready;
  logic                  r_wready;
  logic                  r_aw_held;
  logic                  r_w_held;
  logic                  r_bvalid;
  axil_resp_t            r_bresp;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;

  // Read channel state
  logic                  r_arready;
  logic                  r_rvalid;
  logic                  r_rzero;
  axil_resp_t            r_rresp;

  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_aw_have;
  logic                  w_w_have;
  logic                  w_commit;
  logic                  w_b_done;
  logic                  w_aw_held_nxt;
  logic                  w_w_held_nxt;
  logic                  w_bvalid_nxt;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [STRB_W-1:0]     w_wstrb;
  logic                  w_ram_we;
  axil_resp_t            w_bresp_nxt;

  logic                  w_ar_hs;
  logic                  w_r_done;
  logic                  w_rvalid_nxt;
  logic [ADDR_WIDTH-1:0] w_raddr;
  logic                  w_ram_re;
  logic                  w_rzero_nxt;
  axil_resp_t            w_rresp_nxt;
  logic [DATA_WIDTH-1:0] w_ram_rdata;

  logic                  w_unused;

  // ---------------- write channel combinational ----------------
  assign w_aw_hs   = s_awvalid && r_awready;
  assign w_w_hs    = s_wvalid && r_wready;
  assign w_aw_have = r_aw_held || w_aw_hs;
  assign w_w_have  = r_w_held || w_w_hs;
  // The write happens on the edge where the second half (or both) arrives.
  assign w_commit  = w_aw_have && w_w_have;
  assign w_b_done  = r_bvalid && s_bready;

  assign w_waddr = r_aw_held ? r_awaddr : s_awaddr;
  assign w_wdata = r_w_held  ? r_wdata  : s_wdata;
  assign w_wstrb = r_w_held  ? r_wstrb  : s_wstrb;

  assign w_aw_held_nxt = w_commit ? 1'b0 : w_aw_have;
  assign w_w_held_nxt  = w_commit ? 1'b0 : w_w_have;
  assign w_bvalid_nxt  = w_commit ? 1'b1 : (w_b_done ? 1'b0 : r_bvalid);

  // ---------------- read channel combinational ----------------
  assign w_ar_hs      = s_arvalid && r_arready;
  assign w_r_done     = r_rvalid && s_rready;
  assign w_rvalid_nxt = w_ar_hs ? 1'b1 : (w_r_done ? 1'b0 : r_rvalid);
  assign w_raddr      = s_araddr;

`ifdef AXIL_CHIP_DECERR_EN
  logic w_wr_in_range;
  logic w_rd_in_range;
  // In range when no address bit above the word index is set.
  assign w_wr_in_range = ((w_waddr >> (OFF_W + IDX_W)) == '0);
  assign w_rd_in_range = ((w_raddr >> (OFF_W + IDX_W)) == '0);
  assign w_ram_we      = w_commit && w_wr_in_range && !aresetn;
  assign w_bresp_nxt   = w_wr_in_range ? RESP_OKAY : RESP_DECERR;
  assign w_rzero_nxt   = !w_rd_in_range;
  assign w_rresp_nxt   = w_rd_in_range ? RESP_OKAY : RESP_DECERR;
`else
  // Upper address bits are dropped, so every access aliases into the memory.
  assign w_ram_we      = w_commit && !aresetn;
  assign w_bresp_nxt   = RESP_OKAY;
  assign w_rzero_nxt   = 1'b0;
  assign w_rresp_nxt   = RESP_OKAY;
`endif

  assign w_ram_re = w_ar_hs && !aresetn;

  // Write channel control: holds, response and registered readys.
  always_ff @(posedge aclk) begin
    if (aresetn) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
    end else begin
      r_aw_held <= w_aw_held_nxt;
      r_w_held  <= w_w_held_nxt;
      r_bvalid  <= w_bvalid_nxt;
      if (w_commit) begin
        r_bresp <= w_bresp_nxt;
      end
      r_awready <= !w_aw_held_nxt && !w_bvalid_nxt;
      r_wready  <= !w_w_held_nxt && !w_bvalid_nxt;
    end
  end

  // Capture address/data halves when they arrive ahead of their partner.
  always_ff @(posedge aclk) begin
    if (w_aw_hs) begin
      r_awaddr <= s_awaddr;
    end
    if (w_w_hs) begin
      r_wdata <= s_wdata;
      r_wstrb <= s_wstrb;
    end
  end

  // Read channel control: response valid, code and registered arready.
  always_ff @(posedge aclk) begin
    if (aresetn) begin
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rzero   <= 1'b0;
      r_arready <= 1'b0;
    end else begin
      r_rvalid <= w_rvalid_nxt;
      if (w_ar_hs) begin
        r_rresp <= w_rresp_nxt;
        r_rzero <= w_rzero_nxt;
      end
      r_arready <= !w_rvalid_nxt;
    end
  end

  axil_chip_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_ram (
    .i_clk   (aclk),
    .i_we    (w_ram_we),
    .i_waddr (w_waddr[OFF_W +: IDX_W]),
    .i_wdata (w_wdata),
    .i_wstrb (w_wstrb),
    .i_re    (w_ram_re),
    .i_raddr (w_raddr[OFF_W +: IDX_W]),
    .o_rdata (w_ram_rdata)
  );

  assign s_awready = r_awready;
  assign s_wready  = r_wready;
  assign s_bvalid  = r_bvalid;
  assign s_bresp   = r_bresp;
  assign s_arready = r_arready;
  assign s_rvalid  = r_rvalid;
  assign s_rresp   = r_rresp;
  // Data is forced to zero outside a valid response and for rejected reads.
  assign s_rdata   = (r_rvalid && !r_rzero) ? w_ram_rdata : '0;

  // Protection bits and dropped address bits carry no meaning here.
  assign w_unused = ^{s_awprot, s_arprot, w_waddr, w_raddr};

endmodule

// File: tb/tb_axil_chip.sv
// Scoreboard bench for axil_chip: expectations are queued when a transaction
// is driven and popped when its response appears.
module tb_axil_chip;
  import axil_chip_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;
`ifdef AXIL_CHIP_DECERR_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [AW-1:0] s_awaddr;
  logic [2:0]    s_awprot;
  logic          s_awvalid;
  logic          s_awready;
  logic [DW-1:0] s_wdata;
  logic [3:0]    s_wstrb;
  logic          s_wvalid;
  logic          s_wready;
  logic [1:0]    s_bresp;
  logic          s_bvalid;
  logic          s_bready;
  logic [AW-1:0] s_araddr;
  logic [2:0]    s_arprot;
  logic          s_arvalid;
  logic          s_arready;
  logic [DW-1:0] s_rdata;
  logic [1:0]    s_rresp;
  logic          s_rvalid;
  logic          s_rready;

  axil_chip #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;

  axil_resp_t    exp_bresp_q[$];
  axil_resp_t    exp_rresp_q[$];
  logic [DW-1:0] exp_rdata_q[$];
  logic [DW-1:0] model [DEPTH];

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic bit in_range(input logic [AW-1:0] a);
    return (a >> 12) == 0;
  endfunction

  function automatic int widx(input logic [AW-1:0] a);
    return int'((a >> 2) & (DEPTH - 1));
  endfunction

  // Update the reference memory and queue the write response expected.
  task automatic push_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] st);
    int i;
    if (DEC && !in_range(a)) begin
      exp_bresp_q.push_back(RESP_DECERR);
    end else begin
      i = widx(a);
      for (int b = 0; b < 4; b++) if (st[b]) model[i][b*8 +: 8] = d[b*8 +: 8];
      exp_bresp_q.push_back(RESP_OKAY);
    end
  endtask

  task automatic push_read(input logic [AW-1:0] a);
    if (DEC && !in_range(a)) begin
      exp_rdata_q.push_back('0);
      exp_rresp_q.push_back(RESP_DECERR);
    end else begin
      exp_rdata_q.push_back(model[widx(a)]);
      exp_rresp_q.push_back(RESP_OKAY);
    end
  endtask

  // Full write with bounded wait; returns the observed response.
  task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] st,
                           output logic [1:0] resp, output bit ok);
    bit aw_acc, w_acc;
    push_write(a, d, st);
    s_awaddr = a; s_awvalid = 1'b1;
    s_wdata = d; s_wstrb = st; s_wvalid = 1'b1;
    s_bready = 1'b1;
    ok = 1'b0; resp = 2'bxx;
    for (int c = 0; c < 20; c++) begin
      aw_acc = s_awvalid && s_awready;
      w_acc  = s_wvalid && s_wready;
      tick();
      if (aw_acc) s_awvalid = 1'b0;
      if (w_acc)  s_wvalid  = 1'b0;
      if (s_bvalid) begin resp = s_bresp; ok = 1'b1; break; end
    end
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [AW-1:0] a, output logic [DW-1:0] d,
                          output logic [1:0] resp, output bit ok);
    bit ar_acc;
    push_read(a);
    s_araddr = a; s_arvalid = 1'b1; s_rready = 1'b1;
    ok = 1'b0; resp = 2'bxx; d = 'x;
    for (int c = 0; c < 20; c++) begin
      ar_acc = s_arvalid && s_arready;
      tick();
      if (ar_acc) s_arvalid = 1'b0;
      if (s_rvalid) begin d = s_rdata; resp = s_rresp; ok = 1'b1; break; end
    end
    tick();
    s_arvalid = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b1;
    s_awaddr = '0; s_awprot = '0; s_awvalid = 1'b0;
    s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0; s_bready = 1'b0;
    s_araddr = '0; s_arprot = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    repeat (5) tick();
    n_checks++;
    if ({s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rresp, s_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: aw=%b w=%b bv=%b br=%b ar=%b rv=%b rr=%b rd=%h, required all 0",
               s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rresp, s_rdata);
    end
    aresetn = 1'b0;
    tick();
    n_checks++;
    if ({s_awready, s_wready, s_arready} !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_release_readys: got %b required 111", {s_awready, s_wready, s_arready});
    end
  endtask

  task automatic test_write_read();
    axil_resp_t eb, er;
    logic [DW-1:0] ed;
    push_write(32'h10, 32'hDEADBEEF, 4'hF);
    s_awaddr = 32'h10; s_awvalid = 1'b1; s_wdata = 32'hDEADBEEF; s_wstrb = 4'hF; s_wvalid = 1'b1;
    s_bready = 1'b1;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    eb = exp_bresp_q.pop_front();
    n_checks++;
    if (s_bvalid !== 1'b1 || s_bresp !== eb || s_awready !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_same_cycle: bvalid=%b bresp=%b awready=%b, required 1 %b 0", s_bvalid, s_bresp, s_awready, eb);
    end
    tick();
    n_checks++;
    if ({s_bvalid, s_awready, s_wready} !== 3'b011) begin
      n_fail++;
      $display("FAIL wr_b_handshake: {bvalid,awready,wready}=%b required 011", {s_bvalid, s_awready, s_wready});
    end
    push_read(32'h10);
    s_araddr = 32'h10; s_arvalid = 1'b1; s_rready = 1'b1;
    tick();
    s_arvalid = 1'b0;
    ed = exp_rdata_q.pop_front(); er = exp_rresp_q.pop_front();
    n_checks++;
    if (s_rvalid !== 1'b1 || s_rdata !== ed || s_rresp !== er || s_arready !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_latency: rvalid=%b rdata=%h rresp=%b arready=%b, required 1 %h %b 0",
               s_rvalid, s_rdata, s_rresp, s_arready, ed, er);
    end
    n_checks++;
    if (s_rdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL rd_deadbeef: rdata=%h required deadbeef", s_rdata);
    end
    tick();
    n_checks++;
    if ({s_rvalid, s_arready} !== 2'b01) begin
      n_fail++;
      $display("FAIL rd_r_handshake: {rvalid,arready}=%b required 01", {s_rvalid, s_arready});
    end
  endtask

  task automatic test_split();
    logic [1:0] r; bit ok;
    logic [DW-1:0] d, ed;
    axil_resp_t eb;
    axi_write(32'h30, 32'h0, 4'hF, r, ok);
    eb = exp_bresp_q.pop_front();
    n_checks++;
    if (!ok || r !== eb) begin n_fail++; $display("FAIL split_prewrite: bresp=%b ok=%0d required %b", r, ok, eb); end
    s_wdata = 32'hCAFEF00D; s_wstrb = 4'hF; s_wvalid = 1'b1; s_bready = 1'b0;
    tick();
    s_wvalid = 1'b0;
    n_checks++;
    if ({s_wready, s_awready, s_bvalid} !== 3'b010) begin
      n_fail++;
      $display("FAIL split_w_held: {wready,awready,bvalid}=%b required 010", {s_wready, s_awready, s_bvalid});
    end
    push_read(32'h30);
    s_araddr = 32'h30; s_arvalid = 1'b1; s_rready = 1'b1;
    tick();
    s_arvalid = 1'b0;
    ed = exp_rdata_q.pop_front(); void'(exp_rresp_q.pop_front());
    n_checks++;
    if (s_rvalid !== 1'b1 || s_rdata !== ed || s_bvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL split_no_early_commit: rvalid=%b rdata=%h bvalid=%b, required 1 %h 0", s_rvalid, s_rdata, s_bvalid, ed);
    end
    tick();
    tick();
    push_write(32'h30, 32'hCAFEF00D, 4'hF);
    s_awaddr = 32'h30; s_awvalid = 1'b1;
    tick();
    s_awvalid = 1'b0;
    eb = exp_bresp_q.pop_front();
    n_checks++;
    if (s_bvalid !== 1'b1 || s_bresp !== eb) begin
      n_fail++;
      $display("FAIL split_commit_on_aw: bvalid=%b bresp=%b required 1 %b", s_bvalid, s_bresp, eb);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if ({s_bvalid, s_awready, s_wready} !== 3'b100) begin
        n_fail++;
        $display("FAIL split_bready_hold[%0d]: {bvalid,awready,wready}=%b required 100", i, {s_bvalid, s_awready, s_wready});
      end
    end
    s_bready = 1'b1;
    tick();
    n_checks++;
    if ({s_bvalid, s_awready, s_wready} !== 3'b011) begin
      n_fail++;
      $display("FAIL split_release: {bvalid,awready,wready}=%b required 011", {s_bvalid, s_awready, s_wready});
    end
    axi_read(32'h30, d, r, ok);
    ed = exp_rdata_q.pop_front(); void'(exp_rresp_q.pop_front());
    n_checks++;
    if (!ok || d !== ed || d !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL split_readback: rdata=%h ok=%0d required %h", d, ok, ed);
    end
  endtask

  task automatic test_strobe();
    logic [1:0] r; bit ok;
    logic [DW-1:0] d, ed;
    axil_resp_t eb, er;
    axi_write(32'h20, 32'h11223344, 4'hF, r, ok);
    void'(exp_bresp_q.pop_front());
    axi_write(32'h20, 32'hAABBCCDD, 4'b0101, r, ok);
    eb = exp_bresp_q.pop_front();
    n_checks++;
    if (!ok || r !== eb) begin n_fail++; $display("FAIL strb_partial_bresp: %b ok=%0d required %b", r, ok, eb); end
    axi_write(32'h20, 32'hFFFFFFFF, 4'b0000, r, ok);
    eb = exp_bresp_q.pop_front();
    n_checks++;
    if (!ok || r !== eb || r !== RESP_OKAY) begin n_fail++; $display("FAIL strb_zero_bresp: %b ok=%0d required 00", r, ok); end
    axi_read(32'h20, d, r, ok);
    ed = exp_rdata_q.pop_front(); er = exp_rresp_q.pop_front();
    n_checks++;
    if (!ok || d !== ed || d !== 32'h11BB33DD || r !== er) begin
      n_fail++;
      $display("FAIL strb_readback: rdata=%h rresp=%b required 11bb33dd %b", d, r, er);
    end
  endtask

  task automatic test_backpressure_collision();
    logic [1:0] r; bit ok;
    logic [DW-1:0] d, ed;
    axil_resp_t eb;
    push_read(32'h10);
    ed = exp_rdata_q.pop_front(); void'(exp_rresp_q.pop_front());
    s_araddr = 32'h10; s_arvalid = 1'b1; s_rready = 1'b0;
    tick();
    s_arvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (s_rvalid !== 1'b1 || s_rdata !== ed || s_arready !== 1'b0) begin
        n_fail++;
        $display("FAIL rready_hold[%0d]: rvalid=%b rdata=%h arready=%b required 1 %h 0", i, s_rvalid, s_rdata, s_arready, ed);
      end
      if (i < 3) tick();
    end
    s_rready = 1'b1;
    tick();
    n_checks++;
    if (s_rvalid !== 1'b0) begin n_fail++; $display("FAIL rready_release: rvalid=%b required 0", s_rvalid); end
    push_read(32'h10);
    push_write(32'h10, 32'h0, 4'hF);
    s_awaddr = 32'h10; s_awvalid = 1'b1; s_wdata = 32'h0; s_wstrb = 4'hF; s_wvalid = 1'b1; s_bready = 1'b1;
    s_araddr = 32'h10; s_arvalid = 1'b1;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    ed = exp_rdata_q.pop_front(); void'(exp_rresp_q.pop_front());
    eb = exp_bresp_q.pop_front();
    n_checks++;
    if (s_rvalid !== 1'b1 || s_rdata !== ed || s_rdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL collision_old_data: rvalid=%b rdata=%h required 1 deadbeef", s_rvalid, s_rdata);
    end
    n_checks++;
    if (s_bvalid !== 1'b1 || s_bresp !== eb) begin
      n_fail++;
      $display("FAIL collision_bresp: bvalid=%b bresp=%b required 1 %b", s_bvalid, s_bresp, eb);
    end
    tick();
    axi_read(32'h10, d, r, ok);
    ed = exp_rdata_q.pop_front(); void'(exp_rresp_q.pop_front());
    n_checks++;
    if (!ok || d !== ed || d !== 32'h0) begin n_fail++; $display("FAIL collision_after: rdata=%h required 0", d); end
  endtask

  task automatic test_out_of_range();
    logic [1:0] r; bit ok;
    logic [DW-1:0] d, ed;
    axil_resp_t eb, er;
    axi_write(32'h0, 32'h12345678, 4'hF, r, ok);
    void'(exp_bresp_q.pop_front());
    axi_write(32'h1000, 32'h55AA55AA, 4'hF, r, ok);
    eb = exp_bresp_q.pop_front();
    n_checks++;
    if (!ok || r !== eb || r !== (DEC ? RESP_DECERR : RESP_OKAY)) begin
      n_fail++;
      $display("FAIL oor_bresp: bresp=%b ok=%0d required %b", r, ok, eb);
    end
    axi_read(32'h1000, d, r, ok);
    ed = exp_rdata_q.pop_front(); er = exp_rresp_q.pop_front();
    n_checks++;
    if (!ok || d !== ed || r !== er) begin
      n_fail++;
      $display("FAIL oor_read: rdata=%h rresp=%b required %h %b", d, r, ed, er);
    end
    axi_read(32'h0, d, r, ok);
    ed = exp_rdata_q.pop_front(); er = exp_rresp_q.pop_front();
    n_checks++;
    if (!ok || d !== ed || d !== (DEC ? 32'h12345678 : 32'h55AA55AA) || r !== er) begin
      n_fail++;
      $display("FAIL oor_alias_word0: rdata=%h rresp=%b required %h %b", d, r, ed, er);
    end
  endtask

  task automatic test_reset_mid();
    s_awaddr = 32'h40; s_awvalid = 1'b1; s_wdata = 32'h01020304; s_wstrb = 4'hF; s_wvalid = 1'b1; s_bready = 1'b0;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    aresetn = 1'b1;
    tick();
    n_checks++;
    if ({s_bvalid, s_awready, s_wready, s_rvalid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL midreset_clear: {bvalid,awready,wready,rvalid}=%b required 0000", {s_bvalid, s_awready, s_wready, s_rvalid});
    end
    aresetn = 1'b0;
    tick();
    s_wvalid = 1'b1; s_wdata = 32'h0A0B0C0D;
    tick();
    s_wvalid = 1'b0;
    aresetn = 1'b1;
    tick();
    aresetn = 1'b0;
    tick();
    s_awaddr = 32'h44; s_awvalid = 1'b1;
    tick();
    s_awvalid = 1'b0;
    n_checks++;
    if ({s_bvalid, s_awready, s_wready} !== 3'b001) begin
      n_fail++;
      $display("FAIL midreset_w_dropped: {bvalid,awready,wready}=%b required 001", {s_bvalid, s_awready, s_wready});
    end
    s_wvalid = 1'b1; s_bready = 1'b1;
    tick();
    s_wvalid = 1'b0;
    tick();
    model[widx(32'h40)] = 32'h01020304;
    model[widx(32'h44)] = 32'h0A0B0C0D;
  endtask

  task automatic test_back_to_back();
    logic [1:0] r; bit ok;
    logic [DW-1:0] d, ed;
    logic [AW-1:0] a;
    axil_resp_t eb, er;
    for (int i = 0; i < 16; i++) begin
      a = 32'h100 + 32'(i * 4);
      axi_write(a, $urandom, 4'hF, r, ok);
      eb = exp_bresp_q.pop_front();
      n_checks++;
      if (!ok || r !== eb) begin n_fail++; $display("FAIL b2b_fill[%0d]: bresp=%b ok=%0d required %b", i, r, ok, eb); end
    end
    for (int i = 0; i < 16; i++) begin
      a = 32'h100 + 32'($urandom_range(0, 15) * 4);
      axi_write(a, $urandom, 4'($urandom_range(0, 15)), r, ok);
      eb = exp_bresp_q.pop_front();
      n_checks++;
      if (!ok || r !== eb) begin n_fail++; $display("FAIL b2b_strb[%0d]: bresp=%b ok=%0d required %b", i, r, ok, eb); end
    end
    for (int i = 0; i < 16; i++) begin
      a = 32'h100 + 32'(i * 4);
      axi_read(a, d, r, ok);
      ed = exp_rdata_q.pop_front(); er = exp_rresp_q.pop_front();
      n_checks++;
      if (!ok || d !== ed || r !== er) begin
        n_fail++;
        $display("FAIL b2b_read[%0d]: rdata=%h rresp=%b ok=%0d required %h %b", i, d, r, ok, ed, er);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_split();
    test_strobe();
    test_backpressure_collision();
    test_out_of_range();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axil_chip.md
Name: axil_chip

Overview:
- Top-level AXI4-Lite slave subsystem: a word-addressed, byte-enabled memory behind an AXI4-Lite slave port.
- Serves as the slave endpoint for the master/passthrough verification environment. The environment issues writes and reads, then scoreboards the responses and read data against its own model.
- Write and read channels are independent. Each channel has one transaction outstanding at a time.

Parameters:
- ADDR_WIDTH, 32: AXI address width in bits.
- DATA_WIDTH, 32: data width in bits; legal values are 32 and 64.
- MEM_DEPTH, 1024: number of DATA_WIDTH words; must be a power of two.

Ports:
- aclk  in  1  Clock. All logic is rising-edge.
- aresetn  in  1  Reset. Synchronous, active-high: 1 = reset. Name retained from the codebase despite the suffix.
- s_awaddr  in  ADDR_WIDTH  Write address.
- s_awprot  in  3  Ignored.
- s_awvalid  in  1  Write address valid.
- s_awready  out  1  Write address ready.
- s_wdata  in  DATA_WIDTH  Write data.
- s_wstrb  in  DATA_WIDTH/8  Byte enables.
- s_wvalid  in  1  Write data valid.
- s_wready  out  1  Write data ready.
- s_bresp  out  2  Write response.
- s_bvalid  out  1  Write response valid.
- s_bready  in  1  Write response ready.
- s_araddr  in  ADDR_WIDTH  Read address.
- s_arprot  in  3  Ignored.
- s_arvalid  in  1  Read address valid.
- s_arready  out  1  Read address ready.
- s_rdata  out  DATA_WIDTH  Read data.
- s_rresp  out  2  Read response.
- s_rvalid  out  1  Read data valid.
- s_rready  in  1  Read data ready.

Behaviour:
- Reset values: every output is 0, including all ready signals. Readys go to 1 in the first cycle after reset is released. Memory contents are not cleared.
- Reset mid-transaction: the transaction is dropped, pending bvalid/rvalid clear, and no memory write occurs unless it had already committed.
- Word index = addr[log2(DATA_WIDTH/8) +: log2(MEM_DEPTH)]. Low byte-offset bits are ignored.
- Write channel, per-channel hold registers:
  - s_awready = !aw_held && !s_bvalid; s_wready = !w_held && !s_bvalid. Both are registered.
  - AW and W may arrive in either order or in the same cycle.
  - At the edge where the second of AW/W is captured, or both together, the memory word is written with byte lanes gated by wstrb. At that same edge s_bvalid goes to 1 and both holds clear.
  - Latency: AW+W accepted at edge N gives s_bvalid=1 during cycle N+1.
  - s_bvalid and s_bresp hold until s_bready. Readys reassert the cycle after the B handshake.
  - wstrb=0 writes nothing and still returns OKAY.
- Read channel:
  - s_arready = !s_rvalid.
  - At the AR handshake edge, memory is sampled into s_rdata and s_rvalid goes to 1 (data in cycle N+1).
  - s_rdata and s_rresp hold until s_rready. s_arready reasserts the cycle after the R handshake.
- Read and write to the same word committing at the same edge: the read returns the old data.
- Response codes: OKAY=00, SLVERR=10, DECERR=11.
- Out-of-range handling (byte address ≥ MEM_DEPTH×DATA_WIDTH/8) is governed by the optional feature below.

Optional Feature:
- Macro: AXIL_CHIP_DECERR_EN.
- Defined:
  - Out-of-range write: memory is not modified; bresp=DECERR.
  - Out-of-range read: rdata=0; rresp=DECERR.
  - In-range accesses return OKAY.
- Undefined: the address wraps modulo the memory size, and every response is OKAY.

Decomposition:
- Package axil_chip_pkg:
  - Response constants RESP_OKAY, RESP_SLVERR, RESP_DECERR.
  - typedef axil_resp_t (2 bits).
  - Default width and depth constants.
- Sub-module axil_chip_ram: one synchronous byte-enabled write port plus one synchronous read port, with read-old-data semantics on same-edge collision.
- The AXI channel control stays in axil_chip.

Test Plan:
- Reset: hold aresetn=1 for 5 cycles → all outputs 0; after release, awready, wready and arready are 1.
- Write 0xDEADBEEF to 0x10 (wstrb=F), AW and W in the same cycle → bvalid in the next cycle, bresp=00. Then read 0x10 → rdata=0xDEADBEEF, rresp=00, rvalid one cycle after AR.
- Split ordering: W first and AW 3 cycles later → the write commits only when AW arrives. Hold bready=0 for 4 cycles → bvalid stays asserted and awready/wready stay 0.
- Byte strobe: 0x11223344 written to 0x20, then 0xAABBCCDD with wstrb=0101 → reading 0x20 returns 0x11BB33DD.
- Backpressure and collision: read 0x10 with rready=0 for 3 cycles → rdata held stable. A same-edge write of 0x0 and read of 0x10 → read returns 0xDEADBEEF.
- Out of range at 0x1000 (DEPTH 1024) with AXIL_CHIP_DECERR_EN defined → bresp=11, rresp=11, rdata=0. Without the macro → the access aliases to 0x0 and returns 00.
